// File: rtl/pwr_reset_seq_pkg.sv
// Shared types and constants for the power-up / reset sequencer.
// The state codes are visible on SEQ_STATE, so keep these encodings fixed.
package pwr_reset_seq_pkg;

    localparam int SEQ_STATE_W     = 3;
    localparam int DEF_PU_CYCLES   = 16;
    localparam int DEF_RES_CYCLES  = 8;
    localparam int DEF_CPU_CYCLES  = 4;
    localparam int DEF_DEB_CYCLES  = 3;
    localparam int DEF_CNT_W       = 8;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_PWR_WAIT = 3'd1,
        ST_RES_WAIT = 3'd2,
        ST_CPU_WAIT = 3'd3,
        ST_CE_EN    = 3'd4,
        ST_RUN      = 3'd5
    } seq_state_e;

    // The three states whose dwell is measured by the shared counter
    function automatic logic is_timed(seq_state_e s);
        return (s == ST_PWR_WAIT) || (s == ST_RES_WAIT) || (s == ST_CPU_WAIT);
    endfunction

endpackage

// File: rtl/pwr_reset_seq_ctrl_if.sv
// Control/status bundle between the sequencer (slave) and the surrounding
// system (master): clock-stable and restart requests in, qualifiers out.
interface pwr_reset_seq_ctrl_if;
    import pwr_reset_seq_pkg::*;

    logic                   CLK_STABLE;
    logic                   SW_RESTART;
    logic                   PUONOUT;
    logic                   RESB;
    logic                   CPURSOUTB;
    logic                   CE0;
    logic                   SEQ_DONE;
    logic [SEQ_STATE_W-1:0] SEQ_STATE;

    modport master (
        output CLK_STABLE, SW_RESTART,
        input  PUONOUT, RESB, CPURSOUTB, CE0, SEQ_DONE, SEQ_STATE
    );

    modport slave (
        input  CLK_STABLE, SW_RESTART,
        output PUONOUT, RESB, CPURSOUTB, CE0, SEQ_DONE, SEQ_STATE
    );

endinterface

// File: rtl/ext_resb_filter.sv
// Synchronizes the asynchronous EXT_RESB pin and debounces its release.
// A low sample drops 'released' immediately; release needs DEB_CYCLES highs.
module ext_resb_filter #(
    parameter int DEB_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ext_resb,
    output logic o_released
);

    localparam logic [CNT_W-1:0] L_DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_deb_cnt;
    logic             r_released;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_deb_cnt  <= '0;
            r_released <= 1'b0;
        end else begin
            r_sync1 <= i_ext_resb;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_deb_cnt  <= '0;
                r_released <= 1'b0;
            end else if (!r_released) begin
                // The counter holds at its last value once released is set
                if (r_deb_cnt == L_DEB_LAST) begin
                    r_released <= 1'b1;
                end else begin
                    r_deb_cnt <= r_deb_cnt + L_ONE;
                end
            end
        end
    end

    assign o_released = r_released;

endmodule

// File: rtl/pwr_reset_seq_ctrl.sv
// Power-up / reset sequencer: walks PUONOUT, RESB, CPURSOUTB, CE0 high in a
// fixed order with programmable dwells, aborting to IDLE on reset or clock loss.
module pwr_reset_seq_ctrl
    import pwr_reset_seq_pkg::*;
#(
    parameter int PU_CYCLES  = DEF_PU_CYCLES,
    parameter int RES_CYCLES = DEF_RES_CYCLES,
    parameter int CPU_CYCLES = DEF_CPU_CYCLES,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EXT_RESB,
    pwr_reset_seq_ctrl_if.slave  seq_if
);

    localparam logic [CNT_W-1:0] L_PU_LAST  = CNT_W'(PU_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_RES_LAST = CNT_W'(RES_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_CPU_LAST = CNT_W'(CPU_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

    logic             w_released;
    logic             w_abort;
    seq_state_e       r_state;
    seq_state_e       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_puonout;
    logic             r_resb;
    logic             r_cpursoutb;
    logic             r_ce0;

    ext_resb_filter #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ext_resb_filter (
        .clk        (clk),
        .rst        (rst),
        .i_ext_resb (EXT_RESB),
        .o_released (w_released)
    );

    // Abort beats warm restart, which beats the normal advance
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        w_abort      = !w_released || !seq_if.CLK_STABLE;

        case (r_state)
            ST_IDLE:     if (w_released && seq_if.CLK_STABLE) w_next_state = ST_PWR_WAIT;
            ST_PWR_WAIT: if (r_cnt == L_PU_LAST)  w_next_state = ST_RES_WAIT;
            ST_RES_WAIT: if (r_cnt == L_RES_LAST) w_next_state = ST_CPU_WAIT;
            ST_CPU_WAIT: if (r_cnt == L_CPU_LAST) w_next_state = ST_CE_EN;
            ST_CE_EN:    w_next_state = ST_RUN;
            ST_RUN:      if (seq_if.SW_RESTART) w_next_state = ST_RES_WAIT;
            default:     w_next_state = ST_IDLE;
        endcase

        if (r_state != ST_IDLE && w_abort) begin
            w_next_state = ST_IDLE;
        end

        if (w_next_state == r_state && is_timed(r_state)) begin
            w_next_cnt = r_cnt + L_ONE;
        end
    end

    // Qualifiers are registered from the next state so they line up with SEQ_STATE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_puonout   <= 1'b0;
            r_resb      <= 1'b0;
            r_cpursoutb <= 1'b0;
            r_ce0       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_puonout   <= (w_next_state == ST_RES_WAIT) || (w_next_state == ST_CPU_WAIT) ||
                           (w_next_state == ST_CE_EN)    || (w_next_state == ST_RUN);
            r_resb      <= (w_next_state == ST_CPU_WAIT) || (w_next_state == ST_CE_EN) ||
                           (w_next_state == ST_RUN);
            r_cpursoutb <= (w_next_state == ST_CE_EN) || (w_next_state == ST_RUN);
            r_ce0       <= (w_next_state == ST_RUN);
        end
    end

    assign seq_if.PUONOUT   = r_puonout;
    assign seq_if.RESB      = r_resb;
    assign seq_if.CPURSOUTB = r_cpursoutb;
    assign seq_if.CE0       = r_ce0;
    assign seq_if.SEQ_DONE  = r_ce0;
    assign seq_if.SEQ_STATE = r_state;

endmodule
